// File: rtl/demux_s2p.sv
// Serial-to-parallel demultiplexer: gathers a sync-aligned, valid-qualified bit stream into WIDTH-bit words.
// Optional macro DEMUX_S2P_MSB_FIRST_EN places the first bit after sync in outData[WIDTH-1] instead of outData[0].
module demux_s2p #(
   parameter  int WIDTH = 8,
   localparam int SEL_W = $clog2(WIDTH)
) (
   input  logic             inClk,
   input  logic             inRstN,
   input  logic             inData,
   input  logic             inValid,
   input  logic             inSync,
   output logic [WIDTH-1:0] outData,
   output logic             outValid,
   output logic [SEL_W-1:0] outSel,
   output logic             outBusy,
   output logic             outErr
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_FILL  = 1'b1;
   localparam logic [SEL_W-1:0] SEL_ZERO = '0;
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

   logic [0:0]       r_state;
   logic [SEL_W-1:0] r_sel;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_err;

   logic [SEL_W-1:0] w_arr;
   logic [SEL_W-1:0] w_pos;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_word_next;
   logic             w_start;
   logic             w_accept;
   logic             w_last;

   // A sync always restarts arrival order at 0; a fresh word starts from a cleared register.
   assign w_start  = inValid && inSync;
   assign w_accept = inValid && !inSync && (r_state == ST_FILL);
   assign w_last   = w_accept && (r_sel == SEL_LAST);
   assign w_arr    = inSync ? SEL_ZERO : r_sel;
   assign w_base   = (inSync || (r_sel == SEL_ZERO)) ? '0 : r_word;

`ifdef DEMUX_S2P_MSB_FIRST_EN
   assign w_pos = SEL_LAST - w_arr;
`else
   assign w_pos = w_arr;
`endif

   assign w_word_next = w_base | (WIDTH'(inData) << w_pos);

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         r_state <= ST_IDLE;
         r_sel   <= SEL_ZERO;
         r_word  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_start) begin
            // Realignment with bits already collected throws the partial word away.
            r_err   <= (r_state == ST_FILL) && (r_sel != SEL_ZERO);
            r_state <= ST_FILL;
            r_sel   <= SEL_ONE;
            r_word  <= w_word_next;
         end else if (w_accept) begin
            r_word <= w_word_next;
            if (w_last) begin
               r_data  <= w_word_next;
               r_valid <= 1'b1;
               r_sel   <= SEL_ZERO;
            end else begin
               r_sel <= r_sel + SEL_ONE;
            end
         end
      end
   end

   assign outData  = r_data;
   assign outValid = r_valid;
   assign outSel   = r_sel;
   assign outBusy  = (r_state == ST_FILL);
   assign outErr   = r_err;

endmodule

// File: tb/tb_demux_s2p.sv
// Self-checking bench for demux_s2p: directed scenarios plus a randomized stream against a queue-based model.
// Honours DEMUX_S2P_MSB_FIRST_EN so the same bench covers both bit orders.
module tb_demux_s2p;

   localparam int WIDTH = 8;
   localparam int SEL_W = $clog2(WIDTH);

   logic             inClk = 1'b0;
   logic             inRstN = 1'b0;
   logic             inData = 1'b0;
   logic             inValid = 1'b0;
   logic             inSync = 1'b0;
   logic [WIDTH-1:0] outData;
   logic             outValid;
   logic [SEL_W-1:0] outSel;
   logic             outBusy;
   logic             outErr;

   int checks = 0;
   int errors = 0;

   bit               m_q[$];
   bit               m_busy = 1'b0;
   logic [WIDTH-1:0] e_data = '0;
   logic             e_valid = 1'b0;
   logic             e_err = 1'b0;
   logic [SEL_W-1:0] e_sel = '0;

   demux_s2p #(.WIDTH(WIDTH)) dut (
      .inClk   (inClk),
      .inRstN  (inRstN),
      .inData  (inData),
      .inValid (inValid),
      .inSync  (inSync),
      .outData (outData),
      .outValid(outValid),
      .outSel  (outSel),
      .outBusy (outBusy),
      .outErr  (outErr)
   );

   always #5 inClk = ~inClk;

   // Word value from arrival-ordered bits.
   function automatic logic [WIDTH-1:0] pack_bits();
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < m_q.size(); i++) begin
`ifdef DEMUX_S2P_MSB_FIRST_EN
         w[WIDTH-1-i] = m_q[i];
`else
         w[i] = m_q[i];
`endif
      end
      return w;
   endfunction

   // Serial bit i to send so that the completed word equals w.
   function automatic logic ser_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef DEMUX_S2P_MSB_FIRST_EN
      return w[WIDTH-1-i];
`else
      return w[i];
`endif
   endfunction

   function automatic logic [WIDTH+SEL_W+2:0] got_vec();
      return {outData, outValid, outSel, outBusy, outErr};
   endfunction

   function automatic logic [WIDTH+SEL_W+2:0] exp_vec();
      return {e_data, e_valid, e_sel, logic'(m_busy), e_err};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_busy  = 1'b0;
      e_data  = '0;
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_sel   = '0;
   endtask

   task automatic model_step(input logic d, input logic v, input logic s);
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (v) begin
         if (s) begin
            if (m_busy && m_q.size() != 0) e_err = 1'b1;
            m_q.delete();
            m_q.push_back(d);
            m_busy = 1'b1;
         end else if (m_busy) begin
            m_q.push_back(d);
            if (m_q.size() == WIDTH) begin
               e_data  = pack_bits();
               e_valid = 1'b1;
               m_q.delete();
            end
         end
      end
      e_sel = SEL_W'(m_q.size());
   endtask

   // Drive one cycle; returns at posedge+1 with the model updated.
   task automatic cyc(input logic d, input logic v, input logic s);
      inData  = d;
      inValid = v;
      inSync  = s;
      @(posedge inClk);
      model_step(d, v, s);
      #1;
   endtask

   task automatic apply_reset();
      inRstN  = 1'b0;
      inData  = 1'b0;
      inValid = 1'b0;
      inSync  = 1'b0;
      model_reset();
      repeat (2) @(posedge inClk);
      #1;
      inRstN = 1'b1;
   endtask

   task automatic test_reset();
      inRstN = 1'b0;
      model_reset();
      repeat (2) @(posedge inClk);
      #1;
      checks++; if (outData !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", outData); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", outValid); end
      checks++; if (outSel !== '0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", outSel); end
      checks++; if (outBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", outBusy); end
      checks++; if (outErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", outErr); end
      inRstN = 1'b1;
   endtask

   task automatic test_known_word();
      logic [7:0] bits;
      logic [7:0] exp_w;
      bits = 8'b0100_1101;
`ifdef DEMUX_S2P_MSB_FIRST_EN
      exp_w = 8'hB2;
`else
      exp_w = 8'h4D;
`endif
      for (int i = 0; i < 8; i++) begin
         cyc(bits[i], 1'b1, i == 0);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL known_word cyc%0d: got %h expected %h", i, got_vec(), exp_vec());
         end
      end
      checks++; if (outData !== exp_w || outValid !== 1'b1 || outErr !== 1'b0) begin
         errors++; $display("FAIL known_word_value: got data=%h v=%b err=%b expected data=%h v=1 err=0", outData, outValid, outErr, exp_w);
      end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (outValid !== 1'b0 || outData !== exp_w) begin
         errors++; $display("FAIL known_word_hold: got data=%h v=%b expected data=%h v=0", outData, outValid, exp_w);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] words[2];
      int               pulse_at[$];
      logic [WIDTH-1:0] pulse_data[$];
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < WIDTH; i++) begin
            cyc(ser_bit(words[w], i), 1'b1, (w == 0) && (i == 0));
            checks++;
            if (got_vec() !== exp_vec()) begin
               errors++; $display("FAIL back_to_back w%0d b%0d: got %h expected %h", w, i, got_vec(), exp_vec());
            end
            if (outValid === 1'b1) begin
               pulse_at.push_back(w * WIDTH + i);
               pulse_data.push_back(outData);
            end
         end
         checks++; if (outSel !== '0) begin errors++; $display("FAIL back_to_back_wrap: got sel=%0d expected 0", outSel); end
      end
      checks++;
      if (pulse_at.size() != 2) begin
         errors++; $display("FAIL back_to_back_pulses: got %0d pulses expected 2", pulse_at.size());
      end else if (pulse_at[1] - pulse_at[0] != WIDTH || pulse_data[0] !== 8'hA5 || pulse_data[1] !== 8'h3C) begin
         errors++; $display("FAIL back_to_back_words: got gap=%0d %h,%h expected gap=8 a5,3c",
                            pulse_at[1] - pulse_at[0], pulse_data[0], pulse_data[1]);
      end
   endtask

   task automatic test_gapped();
      int vcount;
      int first_valid;
      vcount = 0;
      first_valid = -1;
      for (int i = 0; i < 2 * WIDTH - 1; i++) begin
         logic v;
         logic [SEL_W-1:0] sel_before;
         v = (i % 2 == 0);
         sel_before = outSel;
         cyc(1'b1, v, i == 0);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL gapped cyc%0d: got %h expected %h", i, got_vec(), exp_vec());
         end
         if (!v) begin
            checks++; if (outSel !== sel_before) begin errors++; $display("FAIL gapped_hold cyc%0d: got sel=%0d expected %0d", i, outSel, sel_before); end
         end
         if (outValid === 1'b1 && first_valid < 0) first_valid = i;
      end
      checks++; if (first_valid != 2 * WIDTH - 2 || outData !== 8'hFF) begin
         errors++; $display("FAIL gapped_done: got valid at cyc%0d data=%h expected cyc%0d data=ff", first_valid, outData, 2 * WIDTH - 2);
      end
   endtask

   task automatic test_realign();
      int n_err;
      int n_valid;
      n_err = 0;
      n_valid = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(logic'($urandom_range(1)), 1'b1, i == 0);
         if (outErr === 1'b1) n_err++;
         if (outValid === 1'b1) n_valid++;
      end
      for (int i = 0; i < WIDTH; i++) begin
         cyc(ser_bit(8'h81, i), 1'b1, i == 0);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL realign b%0d: got %h expected %h", i, got_vec(), exp_vec());
         end
         if (i == 0) begin
            checks++; if (outErr !== 1'b1) begin errors++; $display("FAIL realign_err: got %b expected 1", outErr); end
         end
         if (outErr === 1'b1) n_err++;
         if (outValid === 1'b1) n_valid++;
      end
      checks++; if (n_err != 1 || n_valid != 1 || outData !== 8'h81) begin
         errors++; $display("FAIL realign_summary: got err=%0d valid=%0d data=%h expected 1 1 81", n_err, n_valid, outData);
      end
   endtask

   task automatic test_no_sync();
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         if (i < 10) cyc(logic'($urandom_range(1)), 1'b1, 1'b0);
         else        cyc(logic'($urandom_range(1)), 1'b0, 1'b1);
         checks++;
         if (outBusy !== 1'b0 || outSel !== '0 || outValid !== 1'b0 || outErr !== 1'b0) begin
            errors++; $display("FAIL no_sync cyc%0d: got busy=%b sel=%0d v=%b err=%b expected 0 0 0 0", i, outBusy, outSel, outValid, outErr);
         end
      end
   endtask

   task automatic test_async_reset();
      int n_err;
      n_err = 0;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0);
      #2;
      inRstN = 1'b0;
      model_reset();
      #1;
      checks++; if (got_vec() !== '0) begin
         errors++; $display("FAIL async_reset: got %h expected 0", got_vec());
      end
      @(posedge inClk);
      #1;
      checks++; if (got_vec() !== '0) begin errors++; $display("FAIL async_reset_hold: got %h expected 0", got_vec()); end
      inRstN = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         cyc(ser_bit(8'h5A, i), 1'b1, i == 0);
         if (outErr === 1'b1) n_err++;
      end
      checks++; if (outData !== 8'h5A || outValid !== 1'b1 || n_err != 0) begin
         errors++; $display("FAIL async_reset_word: got data=%h v=%b errs=%0d expected 5a 1 0", outData, outValid, n_err);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         cyc(logic'($urandom_range(1)), ($urandom % 4) != 0, ($urandom % 12) == 0);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL random cyc%0d: got %h expected %h", i, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_known_word();
      test_back_to_back();
      test_gapped();
      test_realign();
      test_random();
      test_no_sync();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
